// File: rtl/imem_load_controller.sv
// Boot-time instruction memory loader: host words in, big-endian byte writes out.
// Optional CHECKSUM output enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_controller #(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 10,
    parameter int WORD_LEN = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                LOAD_START,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [WORD_LEN-1:0] IN_WORD,
    input  logic                IN_LAST,
    output logic                MEM_WE,
    output logic [ADDR_W-1:0]   MEM_WADDR,
    output logic [7:0]          MEM_WDATA,
    output logic                CPU_HOLD,
    output logic                LOAD_DONE,
    output logic                LOAD_ERR,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [31:0]         CHECKSUM,
`endif
    output logic [ADDR_W-2:0]   WORD_CNT
);

    typedef enum logic [2:0] {IDLE, WAIT, WR, DONE, ERR} state_t;

    localparam logic [ADDR_W:0] MEM_TOP = (ADDR_W+1)'(MEM_SIZE);

    state_t              state;
    logic [1:0]          bi;
    logic [1:0]          bi_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     ptr_nxt;
    logic [WORD_LEN-1:0] word_q;
    logic                last_q;

    function automatic logic [7:0] byte_sel(input logic [WORD_LEN-1:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign IN_READY = (state == WAIT);
    assign bi_nxt   = bi + 2'd1;
    // One bit wider so a pointer reaching the top of memory does not wrap to 0.
    assign ptr_nxt  = {1'b0, ptr} + (ADDR_W+1)'(4);

    // Word holding register carries data only, so it is left out of reset.
    always_ff @(posedge CLK) begin
        if (state == WAIT && IN_VALID)
            word_q <= IN_WORD;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            bi        <= 2'd0;
            ptr       <= '0;
            last_q    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_WADDR <= '0;
            MEM_WDATA <= '0;
            CPU_HOLD  <= 1'b1;
            LOAD_DONE <= 1'b0;
            LOAD_ERR  <= 1'b0;
            WORD_CNT  <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHECKSUM  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (LOAD_START) begin
                        state     <= WAIT;
                        ptr       <= '0;
                        WORD_CNT  <= '0;
                        CPU_HOLD  <= 1'b1;
                        LOAD_DONE <= 1'b0;
                        LOAD_ERR  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        CHECKSUM  <= '0;
`endif
                    end
                end
                WAIT: begin
                    // Byte 0 goes out on the handshake edge itself.
                    if (IN_VALID) begin
                        state     <= WR;
                        last_q    <= IN_LAST;
                        bi        <= 2'd0;
                        WORD_CNT  <= WORD_CNT + (ADDR_W-1)'(1);
                        MEM_WE    <= 1'b1;
                        MEM_WADDR <= ptr;
                        MEM_WDATA <= byte_sel(IN_WORD, 2'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
                        CHECKSUM  <= {CHECKSUM[30:0], CHECKSUM[31]} ^ IN_WORD;
`endif
                    end
                end
                WR: begin
                    if (bi != 2'd3) begin
                        bi        <= bi_nxt;
                        MEM_WADDR <= ptr + ADDR_W'(bi_nxt);
                        MEM_WDATA <= byte_sel(word_q, bi_nxt);
                    end else begin
                        MEM_WE <= 1'b0;
                        ptr    <= ptr_nxt[ADDR_W-1:0];
                        if (last_q) begin
                            state     <= DONE;
                            CPU_HOLD  <= 1'b0;
                            LOAD_DONE <= 1'b1;
                        end else if (ptr_nxt == MEM_TOP) begin
                            state    <= ERR;
                            LOAD_ERR <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
